// File: rtl/hit_pkg.sv
// Shared widths and the packed hit entry used by the hit pair packer and its FIFO.
package hit_pkg;

    localparam int unsigned SIGFIG = 24;
    localparam int unsigned RADIX  = 10;
    localparam int unsigned AXIS   = 3;
    localparam int unsigned COLORS = 3;

    typedef struct packed {
        logic [AXIS-1:0][SIGFIG-1:0]   hit;
        logic [COLORS-1:0][SIGFIG-1:0] color;
    } hit_entry_t;

    // Whole number to SIGFIG-bit fixed point with RADIX fraction bits.
    function automatic logic [SIGFIG-1:0] fix_from_int(input int v);
        return SIGFIG'(v) << RADIX;
    endfunction

endpackage

// File: rtl/hit_pair_fifo.sv
// DEPTH-entry hit FIFO: one write port, head and head+1 read, pops 0..2 entries per cycle.
module hit_pair_fifo
    import hit_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DEPTH_L2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  hit_entry_t        wdata,
    input  logic [1:0]        pop_cnt,
    output hit_entry_t        head,
    output hit_entry_t        head_nx,
    output logic [DEPTH_L2:0] count
);

    localparam int unsigned CntW = DEPTH_L2 + 1;

    hit_entry_t          mem_q [DEPTH];
    logic [DEPTH_L2-1:0] wr_ptr_q;
    logic [DEPTH_L2-1:0] rd_ptr_q;
    logic [DEPTH_L2-1:0] rd_ptr_nx;
    logic [DEPTH_L2:0]   count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_q + DEPTH_L2'(pop_cnt);
            count_q  <= count_q + CntW'(push) - CntW'(pop_cnt);
        end
    end

    assign rd_ptr_nx = rd_ptr_q + 1'b1;
    assign head      = mem_q[rd_ptr_q];
    assign head_nx   = mem_q[rd_ptr_nx];
    assign count     = count_q;

endmodule

// File: rtl/hit_pair_packer.sv
// Packs one-per-cycle hits two per cycle onto z-buffer lanes 0 and 2, oldest on lane 0.
// Define HIT_PAIR_STATS_EN to add pair/single/stall counters as extra outputs.
module hit_pair_packer
    import hit_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DEPTH_L2 = 2,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXIS-1:0][SIGFIG-1:0]   hit_R17S,
    input  logic [COLORS-1:0][SIGFIG-1:0] color_R17U,
    input  logic                          hit_valid_R17H,
    output logic                          ready_R17H,
    input  logic                          flush_RnnnnH,
    output logic [AXIS-1:0][SIGFIG-1:0]   hit_R18S,
    output logic [COLORS-1:0][SIGFIG-1:0] color_R18U,
    output logic                          hit_valid_R18H,
    output logic [AXIS-1:0][SIGFIG-1:0]   hit_R18S2,
    output logic [COLORS-1:0][SIGFIG-1:0] color_R18U2,
    output logic                          hit_valid_R18H2,
    output logic                          empty_RnnnnH
`ifdef HIT_PAIR_STATS_EN
    ,
    output logic [31:0]                   pairs_RnnnnU,
    output logic [31:0]                   singles_RnnnnU,
    output logic [31:0]                   stalls_RnnnnU
`endif
);

    localparam int unsigned CntW = DEPTH_L2 + 1;

    logic [DEPTH_L2:0] count;
    hit_entry_t        wdata;
    hit_entry_t        head;
    hit_entry_t        head_nx;
    logic              push;
    logic [1:0]        pop_cnt;
    logic [7:0]        wait_q;
    logic [7:0]        wait_d;
    hit_entry_t        lane0_q;
    hit_entry_t        lane2_q;
    logic              valid0_q;
    logic              valid2_q;

    assign ready_R17H  = count < CntW'(DEPTH);
    assign push        = hit_valid_R17H && ready_R17H;
    assign wdata.hit   = hit_R17S;
    assign wdata.color = color_R17U;

    // Pairs always win; a lone entry leaves only after the idle timeout or a flush.
    assign pop_cnt = (count >= CntW'(2)) ? 2'd2 :
                     ((count == CntW'(1)) && ((wait_q == 8'(TIMEOUT)) || flush_RnnnnH)) ? 2'd1 :
                     2'd0;

    hit_pair_fifo #(
        .DEPTH    (DEPTH),
        .DEPTH_L2 (DEPTH_L2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   (wdata),
        .pop_cnt (pop_cnt),
        .head    (head),
        .head_nx (head_nx),
        .count   (count)
    );

    always_comb begin
        wait_d = wait_q;
        if (push || (pop_cnt != 2'd0) || (count != CntW'(1))) begin
            wait_d = '0;
        end else if (wait_q != 8'(TIMEOUT)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q   <= '0;
            valid0_q <= 1'b0;
            valid2_q <= 1'b0;
            lane0_q  <= '0;
            lane2_q  <= '0;
        end else begin
            wait_q   <= wait_d;
            valid0_q <= pop_cnt != 2'd0;
            valid2_q <= pop_cnt == 2'd2;
            if (pop_cnt != 2'd0) begin
                lane0_q <= head;
            end
            if (pop_cnt == 2'd2) begin
                lane2_q <= head_nx;
            end
        end
    end

    assign hit_R18S        = lane0_q.hit;
    assign color_R18U      = lane0_q.color;
    assign hit_valid_R18H  = valid0_q;
    assign hit_R18S2       = lane2_q.hit;
    assign color_R18U2     = lane2_q.color;
    assign hit_valid_R18H2 = valid2_q;
    assign empty_RnnnnH    = (count == '0) && !valid0_q && !valid2_q;

`ifdef HIT_PAIR_STATS_EN
    logic [31:0] pairs_q;
    logic [31:0] singles_q;
    logic [31:0] stalls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pairs_q   <= '0;
            singles_q <= '0;
            stalls_q  <= '0;
        end else begin
            pairs_q   <= pairs_q + 32'(pop_cnt == 2'd2);
            singles_q <= singles_q + 32'(pop_cnt == 2'd1);
            stalls_q  <= stalls_q + 32'(hit_valid_R17H && !ready_R17H);
        end
    end

    assign pairs_RnnnnU   = pairs_q;
    assign singles_RnnnnU = singles_q;
    assign stalls_RnnnnU  = stalls_q;
`endif

endmodule

// File: tb/tb_hit_pair_packer.sv
// Self-checking bench for hit_pair_packer against a queue-based reference model.
module tb_hit_pair_packer;
    import hit_pkg::*;

    localparam int DEPTH    = 4;
    localparam int DEPTH_L2 = 2;
    localparam int TIMEOUT  = 8;
    localparam int W        = $bits(hit_entry_t);

    logic clk = 1'b0;
    logic rst = 1'b1;
    hit_entry_t in_e = '0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;

    logic [AXIS-1:0][SIGFIG-1:0]   hit_in;
    logic [COLORS-1:0][SIGFIG-1:0] color_in;
    logic                          ready;
    logic [AXIS-1:0][SIGFIG-1:0]   hit0;
    logic [COLORS-1:0][SIGFIG-1:0] color0;
    logic                          v0;
    logic [AXIS-1:0][SIGFIG-1:0]   hit2;
    logic [COLORS-1:0][SIGFIG-1:0] color2;
    logic                          v2;
    logic                          empty;
`ifdef HIT_PAIR_STATS_EN
    logic [31:0] pairs_cnt;
    logic [31:0] singles_cnt;
    logic [31:0] stalls_cnt;
`endif

    assign hit_in   = in_e.hit;
    assign color_in = in_e.color;

    hit_pair_packer #(
        .DEPTH    (DEPTH),
        .DEPTH_L2 (DEPTH_L2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hit_R17S        (hit_in),
        .color_R17U      (color_in),
        .hit_valid_R17H  (in_valid),
        .ready_R17H      (ready),
        .flush_RnnnnH    (flush),
        .hit_R18S        (hit0),
        .color_R18U      (color0),
        .hit_valid_R18H  (v0),
        .hit_R18S2       (hit2),
        .color_R18U2     (color2),
        .hit_valid_R18H2 (v2),
        .empty_RnnnnH    (empty)
`ifdef HIT_PAIR_STATS_EN
        ,
        .pairs_RnnnnU    (pairs_cnt),
        .singles_RnnnnU  (singles_cnt),
        .stalls_RnnnnU   (stalls_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    hit_entry_t mq[$];
    int         mwait = 0;
    bit         ev0 = 1'b0;
    bit         ev2 = 1'b0;
    hit_entry_t ed0 = '0;
    hit_entry_t ed2 = '0;
    bit         stall = 1'b0;
    bit         last_pushed = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic hit_entry_t rand_entry();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    task automatic reset_model();
        mq.delete();
        mwait = 0;
        ev0 = 1'b0;
        ev2 = 1'b0;
        ed0 = '0;
        ed2 = '0;
    endtask

    // One clock: predict from the model, advance an edge, compare all outputs.
    task automatic step();
        bit exp_ready;
        bit pushed;
        int npop;
        int sz;
        sz = mq.size();
        exp_ready = sz < DEPTH;
        chk("ready", W'(ready), W'(exp_ready));
        pushed = in_valid && exp_ready;
        if (stall) npop = 0;
        else if (sz >= 2) npop = 2;
        else if (sz == 1 && (mwait == TIMEOUT || flush)) npop = 1;
        else npop = 0;
        ev0 = npop > 0;
        ev2 = npop == 2;
        if (npop > 0) ed0 = mq.pop_front();
        if (npop == 2) ed2 = mq.pop_front();
        if (pushed) mq.push_back(in_e);
        if (pushed || npop > 0 || sz != 1) mwait = 0;
        else if (mwait < TIMEOUT) mwait++;
        last_pushed = pushed;
        @(posedge clk);
        #1;
        chk("valid0", W'(v0), W'(ev0));
        chk("valid2", W'(v2), W'(ev2));
        chk("lane0", {hit0, color0}, ed0);
        chk("lane2", {hit2, color2}, ed2);
        chk("empty", W'(empty), W'(mq.size() == 0 && !ev0 && !ev2));
    endtask

    initial begin
        hit_entry_t a;
        hit_entry_t b;
        int lat;
        int pairs;

        // Reset
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid0", W'(v0), W'(0));
        chk("rst_ready", W'(ready), W'(1));
        chk("rst_empty", W'(empty), W'(1));
        rst = 1'b1;
        reset_model();
        repeat (3) step();

        // Pairing and order: A (x=5.0) then B (x=6.0)
        a = rand_entry();
        a.hit[0] = fix_from_int(5);
        b = rand_entry();
        b.hit[0] = fix_from_int(6);
        in_valid = 1'b1;
        in_e = a;
        step();
        in_e = b;
        step();
        in_valid = 1'b0;
        step();
        chk("pair_a_x", W'(hit0[0]), W'(24'h001400));
        chk("pair_b_x", W'(hit2[0]), W'(24'h001800));
        step();
        chk("pair_empty", W'(empty), W'(1));

        // Lone timeout
        in_valid = 1'b1;
        in_e = rand_entry();
        step();
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (v0 && lat < 0) lat = k;
        end
        chk("lone_latency", W'(lat), W'(TIMEOUT + 1));

        // Flush of a lone entry, then flush with nothing buffered
        in_valid = 1'b1;
        in_e = rand_entry();
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        chk("flush_emit", W'(v0), W'(1));
        step();
        flush = 1'b0;
        step();

        // Back-to-back stream of 10 hits drains as 5 pairs
        pairs = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_e = rand_entry();
            step();
            if (v2) pairs++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (v2) pairs++;
        end
        chk("stream_pairs", W'(pairs), W'(5));

        // Stalled drain fills the FIFO; the held hit must not be captured
        force dut.pop_cnt = 2'd0;
        stall = 1'b1;
        in_valid = 1'b1;
        in_e = rand_entry();
        for (int i = 0; i < 7; i++) begin
            step();
            if (last_pushed) in_e = rand_entry();
        end
        chk("full_ready", W'(ready), W'(0));
        in_valid = 1'b0;
        release dut.pop_cnt;
        stall = 1'b0;
        repeat (5) step();

        // Async reset with 3 entries buffered
        force dut.pop_cnt = 2'd0;
        stall = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_e = rand_entry();
            step();
        end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid0", W'(v0), W'(0));
        chk("arst_valid2", W'(v2), W'(0));
        chk("arst_lane0", {hit0, color0}, W'(0));
        chk("arst_lane2", {hit2, color2}, W'(0));
        chk("arst_ready", W'(ready), W'(1));
        chk("arst_empty", W'(empty), W'(1));
        release dut.pop_cnt;
        stall = 1'b0;
        reset_model();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (12) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
